sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (read-only) and the data requester (load/store from EXE, response consumed in MEM).
- Uses fixed priority with data first, because the data access belongs to the older instruction.
- Once a request is issued it stays locked until the memory accepts its address.
- Responses return in order. An in-order ID FIFO routes each data_ok and its rdata back to the requester that issued it.
- Sits between the CPU core and the SRAM-to-AXI bridge or unified SRAM.

---
 rtl/sram_req_arbiter_pkg.sv | 25 ++
 rtl/sram_req_arbiter_id_fifo.sv | 70 +++++++
 rtl/sram_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_req_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_arbiter_pkg
// Description : Shared constants for the SRAM request arbiter: requester IDs,
//               arbiter state encodings and SRAM transfer size encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_req_arbiter_pkg;

  // Requester IDs stored in the in-order response FIFO
  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  // Arbiter states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_I = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  // SRAM-like transfer sizes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage : sram_req_arbiter_pkg
`default_nettype wire

// File: rtl/sram_req_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : req_id_fifo
// Description : 1-bit-wide synchronous FIFO holding requester IDs of
//               accepted-but-unanswered memory requests.
// Ports       : clk, reset (sync, active-high)
//               i_push/i_din  - enqueue an ID (ignored when full)
//               i_pop         - dequeue head (ignored when empty)
//               o_head        - ID at the head
//               o_full/o_empty/o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module req_id_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_din,
  input  logic             i_pop,
  output logic             o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Explicit wrap so non-power-of-two depths also behave
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= f_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : req_id_fifo
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_arbiter
// Description : Shares one SRAM-like port between the instruction-fetch and
//               data requesters. Fixed priority (data first), a granted
//               request stays locked until its address is accepted, and an
//               in-order ID FIFO routes each response to its requester.
// Ports       : inst_*  - fetch requester (read-only, word)
//               data_*  - load/store requester
//               mem_*   - shared memory port
// Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_grant_i;
  logic             w_grant_d;
  logic             w_handshake;
  logic             w_pop;
  logic             w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_room;
  logic             w_has_entry;

  // Fullness comes from the registered count, so a pop in the same cycle
  // cannot open a slot for a grant until the following cycle.
  assign w_room      = !w_fifo_full;
  assign w_has_entry = !w_fifo_empty && (w_count != '0);

  // Grant: a locked requester keeps the port; otherwise data wins.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_LOCK_I: w_grant_i = 1'b1;
        ST_LOCK_D: w_grant_d = 1'b1;
        default: begin
          if (w_room) begin
            if (data_req) begin
              w_grant_d = 1'b1;
            end else if (inst_req) begin
              w_grant_i = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Field mux; unused fields are zero when the port is idle.
  always_comb begin
    mem_req   = w_grant_i || w_grant_d;
    mem_wr    = 1'b0;
    mem_size  = SIZE_W;
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'h0;
    if (w_grant_d) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end else if (w_grant_i) begin
      mem_addr  = inst_addr;
    end else begin
      mem_size  = SIZE_B;
    end
  end

  assign w_handshake  = mem_req && mem_addr_ok;
  assign inst_addr_ok = w_handshake && w_grant_i;
  assign data_addr_ok = w_handshake && w_grant_d;

  // Responses with nothing outstanding are discarded
  assign w_pop        = !reset && mem_data_ok && w_has_entry;
  assign inst_data_ok = w_pop && (w_fifo_head == REQ_INST);
  assign data_data_ok = w_pop && (w_fifo_head == REQ_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOCK_I, ST_LOCK_D: begin
        if (mem_addr_ok) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        if (mem_req && !mem_addr_ok) begin
          w_state_nxt = w_grant_d ? ST_LOCK_D : ST_LOCK_I;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  req_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_handshake),
    .i_din   (w_grant_d ? REQ_DATA : REQ_INST),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

endmodule : sram_req_arbiter
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_req_arbiter
// Description : Self-checking bench for sram_req_arbiter. A queue-based
//               model predicts every output each cycle; directed sequences
//               add literal expectations for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

  localparam int OUTSTANDING = 2;
  localparam int ADDR_W      = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  // Model: outstanding requester IDs in issue order, and the requester that
  // currently owns the port (-1 = nobody).
  int q[$];
  int owner = -1;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(OUTSTANDING), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle model comparison (sampled on the falling edge)
  initial begin : model
    int eg, head;
    bit popv;
    logic [4:0]  e_ctl;
    logic [70:0] e_fld, a_fld;
    logic [31:0] e_rd, a_rd;
    forever begin
      @(negedge clk);
      eg = -1;
      if (!reset) begin
        if (owner >= 0) eg = owner;
        else if (q.size() < OUTSTANDING) eg = data_req ? 1 : (inst_req ? 0 : -1);
      end
      popv = !reset && mem_data_ok && (q.size() > 0);
      head = popv ? q[0] : -1;
      e_ctl = {eg >= 0, eg == 0 && mem_addr_ok, eg == 1 && mem_addr_ok, head == 0, head == 1};
      check("ctl", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, e_ctl);
      if (eg >= 0) begin
        e_fld = (eg == 1) ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                          : {1'b0, 2'd2, inst_addr, 4'b0000, 32'h0};
        a_fld = {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata};
        check("fields", a_fld, e_fld);
      end
      if (popv) begin
        e_rd = mem_rdata;
        a_rd = (head == 0) ? inst_rdata : data_rdata;
        check("rdata", a_rd, e_rd);
      end
      @(posedge clk);
      if (reset) begin
        q.delete();
        owner = -1;
      end else begin
        if (popv) void'(q.pop_front());
        if (eg >= 0) begin
          if (e_ctl[3] || e_ctl[2]) begin
            q.push_back(eg);
            owner = -1;
          end else begin
            owner = eg;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal checks land at posedge+4, before the model samples at negedge
  task automatic settle();
    #3;
  endtask

  initial begin : stim
    reset = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
    data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    tick(); tick();
    settle();
    check("reset_outs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b0);
    tick(); reset = 1'b0;

    // Both requests in the same cycle: data first, then inst
    tick();
    inst_req = 1; inst_addr = 32'h1c000000;
    data_req = 1; data_addr = 32'h10; data_wr = 0; data_size = 2'd2;
    mem_addr_ok = 1;
    settle();
    check("prio_addr0", {mem_addr, data_addr_ok, inst_addr_ok}, {32'h10, 2'b10});
    tick(); data_req = 0;
    settle();
    check("prio_addr1", {mem_addr, inst_addr_ok, data_addr_ok}, {32'h1c000000, 2'b10});
    tick(); inst_req = 0;
    settle();
    check("model_q", {q.size(), q[0], q[1]}, {32'd2, 32'd1, 32'd0});
    check("dut_count", dut.w_count, 2);

    // Responses return in order
    mem_data_ok = 1; mem_rdata = 32'hAAAA5555;
    settle();
    check("resp0", {data_data_ok, inst_data_ok, data_rdata}, {2'b10, 32'hAAAA5555});
    tick(); mem_rdata = 32'h12345678;
    settle();
    check("resp1", {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'h12345678});
    tick(); mem_data_ok = 0;

    // Lock hold: inst locked while a data request arrives
    mem_addr_ok = 0; inst_req = 1; inst_addr = 32'h1c000040;
    tick(); data_req = 1; data_addr = 32'h20;
    settle();
    check("lock_c1", {mem_addr, data_addr_ok}, {32'h1c000040, 1'b0});
    tick();
    settle();
    check("lock_c2", mem_addr, 32'h1c000040);
    tick(); mem_addr_ok = 1;
    settle();
    check("lock_c3", {mem_addr, inst_addr_ok}, {32'h1c000040, 1'b1});
    tick(); inst_req = 0;
    settle();
    check("lock_c4", {mem_addr, data_addr_ok}, {32'h20, 1'b1});
    tick();

    // FIFO now full (inst, data): requests must wait
    inst_req = 1; data_req = 1; data_addr = 32'h30;
    settle();
    check("full_noreq", mem_req, 1'b0);
    tick(); mem_data_ok = 1; mem_rdata = 32'h0BADF00D;
    settle();
    check("full_pop_nogrant", {mem_req, inst_data_ok}, 2'b01);
    tick(); mem_data_ok = 0;
    settle();
    check("full_grant_next", {mem_req, data_addr_ok, mem_addr}, {2'b11, 32'h30});
    tick(); data_req = 0; inst_req = 0;
    mem_data_ok = 1; mem_rdata = 32'h11;
    tick(); mem_rdata = 32'h22;
    tick(); mem_data_ok = 0;

    // Store passes through unchanged
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h3;
    data_wstrb = 4'b1000; data_wdata = 32'hEF000000;
    settle();
    check("store_fields", {mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata, data_addr_ok},
          {1'b1, 1'b1, 2'd0, 32'h3, 4'b1000, 32'hEF000000, 1'b1});
    tick(); data_req = 0; data_wr = 0; data_size = 2'd2; mem_data_ok = 1; mem_rdata = 32'h5;
    settle();
    check("store_resp", {data_data_ok, inst_data_ok}, 2'b10);
    tick(); mem_data_ok = 0;

    // Reset with two in flight
    inst_req = 1; inst_addr = 32'h1c000100;
    tick(); inst_addr = 32'h1c000104;
    tick(); reset = 1; data_req = 1; mem_data_ok = 1;
    settle();
    check("reset_mid", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b0);
    tick(); reset = 0; inst_req = 0; data_req = 0;
    settle();
    check("post_reset_ignore", {inst_data_ok, data_data_ok}, 2'b00);
    tick(); mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1c000200;
    settle();
    check("post_reset_grant", {mem_req, inst_addr_ok, mem_addr}, {2'b11, 32'h1c000200});
    tick(); inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h77;
    settle();
    check("post_reset_resp", {inst_data_ok, inst_rdata}, {1'b1, 32'h77});
    tick(); mem_data_ok = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sram_req_arbiter
`default_nettype wire
